serial_tx_arbiter: RTL and testbench
====================================

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL be the number of byte requesters (2..8).
REQ-002 Parameter GAP, default 1, SHALL be the number of idle-line cycles inserted after each stop bit (0..15).
REQ-003 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid  input  NREQ  SHALL be per-requester byte-valid flags.
REQ-006 req_data  input  NREQ*8  SHALL carry the requester bytes; requester i occupies bits [8i+7:8i].
REQ-007 req_ready  output  NREQ  SHALL be the per-requester accept strobe, at most one bit high per cycle.
REQ-008 tx_out  output  1  SHALL be the serial line; idle level is 1.
REQ-009 busy  output  1  SHALL be high in every state except IDLE.
REQ-010 grant_id  output  clog2(NREQ)  SHALL identify the requester whose frame is in flight; it holds its value while IDLE.
REQ-011 frame_done  output  1  SHALL pulse high for exactly one cycle, during the STOP-bit cycle.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA, STOP and GAP; one serial bit is emitted per clk.
REQ-013 The transitions SHALL be:
- IDLE->START when any req_valid is high, else stay in IDLE.
- START->DATA.
- DATA->STOP after 8 cycles.
- STOP->GAP if GAP>0, else STOP->IDLE.
- GAP->IDLE after GAP cycles.
REQ-014 In IDLE, req_ready SHALL be asserted combinationally only for the round-robin winner among the valid requesters; the byte SHALL be latched and grant_id updated at that edge.
REQ-015 Round-robin search SHALL start at (last_grant+1) mod NREQ and wrap; last_grant updates only on an accepted handshake.
REQ-016 tx_out SHALL be:
- 1 in IDLE, STOP and GAP.
- 0 in START.
- Latched byte bit k in DATA cycle k, LSB first (k=0..7).
REQ-017 req_ready SHALL be 0 in every non-IDLE state; a requester that drops req_valid before being granted SHALL lose its turn without side effects.
REQ-018 The shift register and bit counter SHALL be 8 bits and 3 bits respectively; the counter SHALL wrap from 7 to 0 on DATA exit.
REQ-019 The GAP counter SHALL be 4 bits; with GAP=0 the minimum frame-to-frame period SHALL be 11 cycles (IDLE + START + 8 DATA + STOP), otherwise 11+GAP.
REQ-020 Changes to req_data or req_valid during a frame SHALL NOT affect the frame in flight.
REQ-021 If only one requester is valid, it SHALL be granted regardless of the pointer.

Reset
REQ-022 While reset is high, the outputs SHALL be: state IDLE, tx_out=1, busy=0, frame_done=0, req_ready all 0, grant_id=0.
REQ-023 Reset SHALL set last_grant=NREQ-1 so that requester 0 has first priority.
REQ-024 Reset asserted mid-frame SHALL abort the frame: tx_out=1 from the next cycle, no frame_done pulse, and the aborted byte is not retransmitted.

Structure
REQ-025 The package serial_tx_pkg SHALL hold the state enum, DATA_BITS=8, START_LEVEL=0 and STOP_LEVEL=1.
REQ-026 Grant selection SHALL be a sub-module rr_arbiter (NREQ-wide request vector, last-grant pointer in, one-hot grant out); the FSM and serializer SHALL stay in serial_tx_arbiter.

Verification
REQ-027 Single byte: reset, then req_valid[2]=1 with byte 0xA5.
- req_ready[2] pulses 1 cycle; grant_id=2.
- tx_out sequence is 0,1,0,1,0,0,1,0,1,1, then GAP ones.
- frame_done pulses once in the STOP cycle.
REQ-028 Round robin: all four requesters valid continuously with bytes 0x10..0x13, GAP=1.
- Grant order is 0,1,2,3,0.
- Each frame starts exactly 12 cycles after the previous one.
REQ-029 Fairness after a skip: last grant=1, requesters 0 and 3 valid -> requester 3 is granted first, then requester 0.
REQ-030 Mid-frame reset: reset asserted during DATA bit 4 for 1 cycle.
- tx_out=1 and busy=0 on the next cycle.
- No frame_done pulse.
- The next grant goes to requester 0.
REQ-031 GAP=0, requester 1 always valid with byte 0xFF.
- tx_out is a repeating 11-cycle pattern: 1 (IDLE), 0, followed by nine 1s.
- req_ready[1] pulses every 11 cycles.
REQ-032 Input change: req_data[0] changes from 0x3C to 0xC3 during DATA -> the serialized byte remains 0x3C.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial transmit arbiter.
// Frame format: start bit, 8 data bits LSB first, stop bit.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } tx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: the search starts one past the last grant and wraps.
// Purely combinational; the caller owns the last-grant register.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [NREQ-1:0]         grant
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW:0]   idx_wide;
    logic [IDW-1:0] idx;
    logic           found;

    // The sum never exceeds 2*NREQ-1, so a single conditional subtract is the modulo.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        idx_wide = '0;
        idx      = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx_wide = {1'b0, last_grant} + (IDW+1)'(off);
            if (idx_wide >= (IDW+1)'(NREQ)) begin
                idx_wide = idx_wide - (IDW+1)'(NREQ);
            end
            idx = idx_wide[IDW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Serializes bytes from NREQ requesters onto one line, picked round-robin,
// with GAP idle cycles after each stop bit.
module serial_tx_arbiter
    import serial_tx_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GAP  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_out,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    frame_done
);

    localparam int IDW = $clog2(NREQ);

    tx_state_e      state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]     gap_cnt_q, gap_cnt_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_idx;
    logic [7:0]      win_byte;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx  = IDW'(i);
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(NREQ-1);
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        req_ready    = '0;
        tx_out       = STOP_LEVEL;
        frame_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready is suppressed during reset so no handshake is lost to it.
                if (|req_valid && !reset) begin
                    req_ready    = grant;
                    state_d      = ST_START;
                    shift_d      = win_byte;
                    grant_id_d   = win_idx;
                    last_grant_d = win_idx;
                end
            end
            ST_START: begin
                tx_out    = START_LEVEL;
                bit_cnt_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                tx_out    = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'(DATA_BITS-1)) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_out     = STOP_LEVEL;
                frame_done = 1'b1;
                gap_cnt_d  = '0;
                state_d    = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == 4'(GAP-1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: one instance with GAP=1 and one with GAP=0, each
// checked every cycle against a frame-position model, plus literal per-scenario expectations.
module tb_serial_tx_arbiter;

    localparam int NREQ = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [NREQ-1:0]   reqValid [2];
    logic [8*NREQ-1:0] reqData  [2];
    logic [NREQ-1:0]   readyOut [2];
    logic              txOut    [2];
    logic              busyOut  [2];
    logic              doneOut  [2];
    logic [1:0]        gidOut   [2];

    int compares   = 0;
    int mismatches = 0;
    int cyc        = 0;

    // Model state: frame position (-1 idle, 0 start, 1..8 data, 9 stop, 10.. gap).
    int         mPos   [2];
    logic [7:0] mByte  [2];
    int         mId    [2];
    int         mLast  [2];
    int         gapLen [2];
    bit         modelLive = 1'b0;
    bit         recordTx [2];

    int grantA[$], grantCycA[$], doneCycA[$];
    int grantB[$], grantCycB[$], doneCycB[$];
    bit txLogA[$], txLogB[$];

    logic [3:0] expReady;
    logic       expTx, expBusy, expDone;
    int         w;

    serial_tx_arbiter #(.NREQ(NREQ), .GAP(1)) dutGap1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid[0]),
        .req_data   (reqData[0]),
        .req_ready  (readyOut[0]),
        .tx_out     (txOut[0]),
        .busy       (busyOut[0]),
        .grant_id   (gidOut[0]),
        .frame_done (doneOut[0])
    );

    serial_tx_arbiter #(.NREQ(NREQ), .GAP(0)) dutGap0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid[1]),
        .req_data   (reqData[1]),
        .req_ready  (readyOut[1]),
        .tx_out     (txOut[1]),
        .busy       (busyOut[1]),
        .grant_id   (gidOut[1]),
        .frame_done (doneOut[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            mismatches++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int u, input logic [3:0] v, input logic [31:0] d);
        reqValid[u] = v;
        reqData[u]  = d;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        grantA.delete(); grantCycA.delete(); doneCycA.delete(); txLogA.delete();
        grantB.delete(); grantCycB.delete(); doneCycB.delete(); txLogB.delete();
    endtask

    function automatic int pickRr(input logic [3:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Compare both DUTs against the model on the falling edge, log observations, then
    // advance the model using the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (modelLive) begin
                expReady = '0;
                if (mPos[u] < 0) begin
                    expTx   = 1'b1;
                    expBusy = 1'b0;
                    expDone = 1'b0;
                    w = pickRr(reqValid[u], mLast[u]);
                    if (!reset && w >= 0) expReady[w] = 1'b1;
                end else begin
                    expBusy = 1'b1;
                    expDone = (mPos[u] == 9);
                    if (mPos[u] == 0)      expTx = 1'b0;
                    else if (mPos[u] <= 8) expTx = mByte[u][mPos[u]-1];
                    else                   expTx = 1'b1;
                end
                checkOutput($sformatf("dut%0d tx_out", u), 32'(txOut[u]), 32'(expTx));
                checkOutput($sformatf("dut%0d busy", u), 32'(busyOut[u]), 32'(expBusy));
                checkOutput($sformatf("dut%0d frame_done", u), 32'(doneOut[u]), 32'(expDone));
                checkOutput($sformatf("dut%0d req_ready", u), 32'(readyOut[u]), 32'(expReady));
                checkOutput($sformatf("dut%0d grant_id", u), 32'(gidOut[u]), mId[u]);
            end

            for (int i = 0; i < NREQ; i++) begin
                if (readyOut[u][i] === 1'b1) begin
                    if (u == 0) begin grantA.push_back(i); grantCycA.push_back(cyc); end
                    else        begin grantB.push_back(i); grantCycB.push_back(cyc); end
                end
            end
            if (doneOut[u] === 1'b1) begin
                if (u == 0) doneCycA.push_back(cyc);
                else        doneCycB.push_back(cyc);
            end
            if (recordTx[u]) begin
                if (u == 0) txLogA.push_back(txOut[u]);
                else        txLogB.push_back(txOut[u]);
            end

            if (reset) begin
                mPos[u]  = -1;
                mLast[u] = NREQ - 1;
                mId[u]   = 0;
            end else if (mPos[u] < 0) begin
                w = pickRr(reqValid[u], mLast[u]);
                if (w >= 0) begin
                    mPos[u]  = 0;
                    mByte[u] = reqData[u][8*w +: 8];
                    mId[u]   = w;
                    mLast[u] = w;
                end
            end else begin
                mPos[u]++;
                if (mPos[u] > 9 + gapLen[u]) mPos[u] = -1;
            end
        end
        if (reset) modelLive = 1'b1;
    end

    // Directed scenarios; each ends with literal expectations on the logged observations.
    initial begin
        int expA5 [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
        int expFF [11] = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int rrOrder [5] = '{0, 1, 2, 3, 0};
        logic [7:0] rebuilt;

        gapLen[0] = 1; gapLen[1] = 0;
        for (int u = 0; u < 2; u++) begin
            mPos[u] = -1; mByte[u] = '0; mId[u] = 0; mLast[u] = NREQ - 1;
            recordTx[u] = 1'b0;
            applyStimulus(u, 4'b0000, 32'h0);
        end

        // Reset values while reset is held
        reset = 1'b1;
        waitCycles(2);
        checkOutput("reset tx_out", 32'(txOut[0]), 1);
        checkOutput("reset busy", 32'(busyOut[0]), 0);
        checkOutput("reset frame_done", 32'(doneOut[0]), 0);
        checkOutput("reset req_ready", 32'(readyOut[0]), 0);
        checkOutput("reset grant_id", 32'(gidOut[0]), 0);
        reset = 1'b0;
        waitCycles(1);

        // Single byte 0xA5 from requester 2
        clearLogs();
        recordTx[0] = 1'b1;
        applyStimulus(0, 4'b0100, 32'h00A5_0000);
        waitCycles(1);
        applyStimulus(0, 4'b0000, 32'h0);
        waitCycles(14);
        recordTx[0] = 1'b0;
        checkOutput("a5 grant count", grantA.size(), 1);
        checkOutput("a5 grant id", grantA[0], 2);
        checkOutput("a5 grant_id out", 32'(gidOut[0]), 2);
        for (int k = 0; k < 11; k++) begin
            checkOutput($sformatf("a5 tx bit %0d", k), 32'(txLogA[k+1]), expA5[k]);
        end
        checkOutput("a5 done count", doneCycA.size(), 1);
        checkOutput("a5 done offset", doneCycA[0] - grantCycA[0], 10);

        // Round robin with all four requesters valid
        reset = 1'b1;
        waitCycles(1);
        checkOutput("rr reset grant_id", 32'(gidOut[0]), 0);
        reset = 1'b0;
        clearLogs();
        applyStimulus(0, 4'b1111, 32'h1312_1110);
        waitCycles(62);
        applyStimulus(0, 4'b0000, 32'h0);
        waitCycles(14);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("rr order %0d", k), grantA[k], rrOrder[k]);
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rr period %0d", k), grantCycA[k+1] - grantCycA[k], 12);
        end

        // Fairness after a skip: last grant 1, then requesters 0 and 3
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        clearLogs();
        applyStimulus(0, 4'b0010, 32'h0000_7700);
        waitCycles(1);
        applyStimulus(0, 4'b0000, 32'h0);
        waitCycles(14);
        checkOutput("lone requester grant", grantA[0], 1);
        clearLogs();
        applyStimulus(0, 4'b1001, 32'h4400_0011);
        waitCycles(14);
        applyStimulus(0, 4'b0000, 32'h0);
        waitCycles(14);
        checkOutput("skip first grant", grantA[0], 3);
        checkOutput("skip second grant", grantA[1], 0);

        // Reset during DATA bit 4 aborts the frame
        clearLogs();
        applyStimulus(0, 4'b0100, 32'h005A_0000);
        waitCycles(1);
        applyStimulus(0, 4'b0000, 32'h0);
        waitCycles(5);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("abort tx_out", 32'(txOut[0]), 1);
        checkOutput("abort busy", 32'(busyOut[0]), 0);
        reset = 1'b0;
        waitCycles(3);
        checkOutput("abort no frame_done", doneCycA.size(), 0);
        applyStimulus(0, 4'b1111, 32'h2222_1111);
        waitCycles(1);
        applyStimulus(0, 4'b0000, 32'h0);
        waitCycles(14);
        checkOutput("abort grant count", grantA.size(), 2);
        checkOutput("abort next grant", grantA[1], 0);

        // GAP=0 instance, requester 1 streaming 0xFF
        clearLogs();
        recordTx[1] = 1'b1;
        applyStimulus(1, 4'b0010, 32'h0000_FF00);
        waitCycles(45);
        applyStimulus(1, 4'b0000, 32'h0);
        recordTx[1] = 1'b0;
        waitCycles(12);
        for (int k = 0; k < 33; k++) begin
            checkOutput($sformatf("ff tx %0d", k), 32'(txLogB[k]), expFF[k % 11]);
        end
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("ff grant id %0d", k), grantB[k], 1);
            checkOutput($sformatf("ff period %0d", k), grantCycB[k+1] - grantCycB[k], 11);
        end

        // Data change mid-frame must not alter the byte in flight
        clearLogs();
        recordTx[0] = 1'b1;
        applyStimulus(0, 4'b0001, 32'h0000_003C);
        waitCycles(3);
        applyStimulus(0, 4'b0001, 32'h0000_00C3);
        waitCycles(12);
        applyStimulus(0, 4'b0000, 32'h0);
        recordTx[0] = 1'b0;
        waitCycles(14);
        rebuilt = '0;
        for (int k = 0; k < 8; k++) rebuilt[k] = txLogA[k+2];
        checkOutput("data change byte", 32'(rebuilt), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
